rs_sel_arb: RTL and testbench
=============================

RS_SEL_ARB -- requirements
Module: rs_sel_arb

Interface
REQ-001 SHALL have parameter RS_SIZE, default `RS_SIZE (16): number of reservation-station entries; power of two, at least 4.
REQ-002 SHALL have parameter RS_BIT, default `RS_BIT (4): entry index width, log2(RS_SIZE).
REQ-003 SHALL have parameter AF_THRESH, default 2: free-entry count at or below which almost_full asserts.
REQ-004 clk_in  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  in  1  reset; asynchronous, active-low.
REQ-006 rdy_in  in  1  global enable; low freezes all state.
REQ-007 flush_in  in  1  pipeline flush (mispredict).
REQ-008 prepared  in  RS_SIZE  entry i holds all operands.
REQ-009 busy  in  RS_SIZE  entry i occupied.
REQ-010 issue_valid  out  1  issue_entry holds a valid pick.
REQ-011 issue_entry  out  RS_BIT  index of the entry to dispatch.
REQ-012 issue_ready  in  1  execution unit accepts the pick this cycle.
REQ-013 alloc_req  in  1  decoder writes a new instruction into alloc_entry this cycle.
REQ-014 alloc_valid  out  1  a free entry is offered.
REQ-015 alloc_entry  out  RS_BIT  offered free entry index.
REQ-016 free_cnt  out  RS_BIT+1  number of free entries, range 0..RS_SIZE.
REQ-017 full  out  1  no free entry (equals !alloc_valid).
REQ-018 almost_full  out  1  free_cnt <= AF_THRESH.

Function
REQ-019 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-020 Issue handshake: a pick SHALL be accepted in a cycle where issue_valid && issue_ready && rdy_in.
REQ-021 While issue_valid && !issue_ready, issue_valid and issue_entry SHALL hold stable.
REQ-022 When issue_valid is low or a pick is accepted, the next pick SHALL be the first index with prepared set, searching upward from rr_ptr and wrapping modulo RS_SIZE; latency is 1 cycle from prepared to issue_valid.
REQ-023 An entry accepted in the current cycle SHALL be masked out of the search for that cycle, so no entry issues twice.
REQ-024 rr_ptr SHALL reset to 0 and, on each accepted pick, load (issue_entry + 1) mod RS_SIZE; it is otherwise unchanged.
REQ-025 If no candidate exists, issue_valid SHALL deassert on the next edge.
REQ-026 Allocation: each cycle alloc_entry SHALL be loaded with the lowest-index entry that has busy clear, excluding alloc_entry when alloc_req && alloc_valid in that cycle.
REQ-027 alloc_valid SHALL be loaded high iff such an entry exists.
REQ-028 alloc_req while alloc_valid is low SHALL be ignored.
REQ-029 free_cnt SHALL be loaded with popcount(~busy), minus 1 when alloc_req && alloc_valid, plus 1 when a pick is accepted, saturating at 0 and RS_SIZE.
REQ-030 full SHALL be loaded as (next free_cnt == 0), and almost_full as (next free_cnt <= AF_THRESH).
REQ-031 When flush_in && rdy_in, the next edge SHALL set issue_valid=0 and rr_ptr=0, and SHALL load alloc_valid/alloc_entry/free_cnt as if busy were all-zero: alloc_entry=0, alloc_valid=1, free_cnt=RS_SIZE, full=0, almost_full=(RS_SIZE<=AF_THRESH).
REQ-032 flush_in SHALL take priority over a simultaneous accept or alloc.
REQ-033 When rdy_in is low, every register SHALL hold, and handshakes and flush SHALL be ignored.

Reset
REQ-034 While rst_in is low, outputs SHALL be: issue_valid=0, issue_entry=0, rr_ptr=0, alloc_valid=1, alloc_entry=0, free_cnt=RS_SIZE, full=0, almost_full=(RS_SIZE<=AF_THRESH).
REQ-035 Reset asserted mid-handshake SHALL discard the pending pick; the first pick after deassertion follows REQ-022 from rr_ptr=0.

Structure
REQ-036 RS_SIZE, RS_BIT and AF_THRESH defaults SHALL live in the shared Const.v include; no local typedefs.
REQ-037 The block SHALL instantiate sub-module rr_find_first (request vector, start index -> found flag, index) twice: issue with start=rr_ptr; allocation with start=0 and a masked request.

Verification (RS_SIZE=16, AF_THRESH=2)
REQ-038 Reset with busy=0 -> alloc_valid=1, alloc_entry=0, free_cnt=16, full=0, issue_valid=0.
REQ-039 prepared={3,7,12}, issue_ready=1 constantly -> picks 3,7,12,3 on consecutive cycles (round-robin wrap), with no repeat while prepared is held.
REQ-040 prepared={5}, issue_ready=0 for 4 cycles -> issue_entry=5 stable; ready=1 -> accept, rr_ptr=6; issue_valid drops the next cycle if prepared clears.
REQ-041 busy=0xFFFE, alloc_req=1 -> alloc_entry=0 taken; next cycle with busy=0xFFFF -> full=1, alloc_valid=0; busy=0xFFFC -> almost_full=1, free_cnt=2.
REQ-042 Flush in the same cycle as an accept plus alloc -> next cycle issue_valid=0, rr_ptr=0, free_cnt=16.
REQ-043 rdy_in=0 for 3 cycles with prepared changing -> all outputs frozen; resume -> pick from the held rr_ptr.

Source files
------------

// File: rtl/rs_sel_arb_pkg.sv
// Shared sizing defaults for the reservation-station select/allocate arbiter.
// Every block that sizes itself to the reservation station imports these.
package rs_sel_arb_pkg;

    localparam int RS_SIZE_DEF   = 16;
    localparam int RS_BIT_DEF    = 4;
    localparam int AF_THRESH_DEF = 2;

endpackage : rs_sel_arb_pkg

// File: rtl/rs_sel_arb_rr_find_first.sv
// Circular first-set-bit finder: searches req upward from start, wrapping modulo N.
// Purely combinational; N must be a power of two with W = log2(N).
module rr_find_first
    import rs_sel_arb_pkg::*;
#(
    parameter int N = RS_SIZE_DEF,
    parameter int W = RS_BIT_DEF
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot_s;
    logic [W-1:0] off_s;

    // Rotate so start sits at bit 0, then take the lowest set bit of the rotated vector.
    always_comb begin
        rot_s = '0;
        off_s = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            rot_s[i] = req[W'(i) + start];
        end
        for (int i = N - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? W'(i) : off_s;
            found = found | rot_s[i];
        end
        idx = start + off_s;
    end

endmodule : rr_find_first

// File: rtl/rs_sel_arb.sv
// Reservation-station arbiter: round-robin issue pick plus lowest-free allocation offer.
// All outputs come straight from registers; rdy_in low freezes every register.
module rs_sel_arb
    import rs_sel_arb_pkg::*;
#(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int RS_BIT    = RS_BIT_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic [RS_SIZE-1:0] prepared,
    input  logic [RS_SIZE-1:0] busy,
    output logic              issue_valid,
    output logic [RS_BIT-1:0] issue_entry,
    input  logic              issue_ready,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [RS_BIT-1:0] alloc_entry,
    output logic [RS_BIT:0]   free_cnt,
    output logic              full,
    output logic              almost_full
);

    localparam logic [RS_SIZE-1:0] ONE_HOT0 = {{(RS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [RS_BIT-1:0]  IDX_ONE  = {{(RS_BIT-1){1'b0}}, 1'b1};
    localparam logic [RS_BIT+1:0]  SIZE_W   = (RS_BIT+2)'(RS_SIZE);
    localparam logic [RS_BIT+1:0]  AF_W     = (RS_BIT+2)'(AF_THRESH);
    localparam logic [RS_BIT:0]    FREE_RST = SIZE_W[RS_BIT:0];
    localparam logic               AF_RST   = (RS_SIZE <= AF_THRESH) ? 1'b1 : 1'b0;

    function automatic logic [RS_BIT:0] popcount(input logic [RS_SIZE-1:0] v);
        logic [RS_BIT:0] c;
        c = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            c = c + {{RS_BIT{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic              issue_valid_r, alloc_valid_r, full_r, almost_full_r;
    logic [RS_BIT-1:0] issue_entry_r, alloc_entry_r, rr_ptr_r;
    logic [RS_BIT:0]   free_cnt_r;

    logic              issue_valid_nxt_s, alloc_valid_nxt_s, full_nxt_s, almost_full_nxt_s;
    logic [RS_BIT-1:0] issue_entry_nxt_s, alloc_entry_nxt_s, rr_ptr_nxt_s;
    logic [RS_BIT:0]   free_cnt_nxt_s, pop_s;
    logic [RS_BIT+1:0] sum_s, dec_s;
    logic              accept_s, take_s;
    logic [RS_SIZE-1:0] iss_req_s, alloc_req_vec_s;
    logic              iss_found_s, alloc_found_s;
    logic [RS_BIT-1:0] iss_idx_s, alloc_idx_s;

    rr_find_first #(.N(RS_SIZE), .W(RS_BIT)) u_issue_find (
        .req   (iss_req_s),
        .start (rr_ptr_r),
        .found (iss_found_s),
        .idx   (iss_idx_s)
    );

    rr_find_first #(.N(RS_SIZE), .W(RS_BIT)) u_alloc_find (
        .req   (alloc_req_vec_s),
        .start ({RS_BIT{1'b0}}),
        .found (alloc_found_s),
        .idx   (alloc_idx_s)
    );

    // Handshakes, search masks and next-state values; flush overrides everything.
    always_comb begin
        accept_s = issue_valid_r && issue_ready && rdy_in;
        take_s   = alloc_req && alloc_valid_r && rdy_in;

        if (accept_s) begin
            iss_req_s = prepared & ~(ONE_HOT0 << issue_entry_r);
        end else begin
            iss_req_s = prepared;
        end
        if (take_s) begin
            alloc_req_vec_s = ~busy & ~(ONE_HOT0 << alloc_entry_r);
        end else begin
            alloc_req_vec_s = ~busy;
        end

        if (!issue_valid_r || accept_s) begin
            issue_valid_nxt_s = iss_found_s;
            issue_entry_nxt_s = iss_found_s ? iss_idx_s : issue_entry_r;
        end else begin
            issue_valid_nxt_s = issue_valid_r;
            issue_entry_nxt_s = issue_entry_r;
        end
        rr_ptr_nxt_s = accept_s ? (issue_entry_r + IDX_ONE) : rr_ptr_r;

        alloc_valid_nxt_s = alloc_found_s;
        alloc_entry_nxt_s = alloc_found_s ? alloc_idx_s : {RS_BIT{1'b0}};

        // Net count change is applied once, then clamped into 0..RS_SIZE.
        pop_s = popcount(~busy);
        sum_s = {1'b0, pop_s} + {{(RS_BIT+1){1'b0}}, accept_s};
        if (take_s && (sum_s == '0)) begin
            dec_s = '0;
        end else begin
            dec_s = sum_s - {{(RS_BIT+1){1'b0}}, take_s};
        end
        if (dec_s > SIZE_W) begin
            free_cnt_nxt_s = FREE_RST;
        end else begin
            free_cnt_nxt_s = dec_s[RS_BIT:0];
        end

        if (flush_in) begin
            issue_valid_nxt_s = 1'b0;
            issue_entry_nxt_s = '0;
            rr_ptr_nxt_s      = '0;
            alloc_valid_nxt_s = 1'b1;
            alloc_entry_nxt_s = '0;
            free_cnt_nxt_s    = FREE_RST;
        end else begin
            rr_ptr_nxt_s = rr_ptr_nxt_s;
        end

        full_nxt_s        = (free_cnt_nxt_s == '0);
        almost_full_nxt_s = ({1'b0, free_cnt_nxt_s} <= AF_W);
    end

    // State registers: async reset, update only while rdy_in is high.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            issue_valid_r <= 1'b0;
            issue_entry_r <= '0;
            rr_ptr_r      <= '0;
            alloc_valid_r <= 1'b1;
            alloc_entry_r <= '0;
            free_cnt_r    <= FREE_RST;
            full_r        <= 1'b0;
            almost_full_r <= AF_RST;
        end else if (rdy_in) begin
            issue_valid_r <= issue_valid_nxt_s;
            issue_entry_r <= issue_entry_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            alloc_valid_r <= alloc_valid_nxt_s;
            alloc_entry_r <= alloc_entry_nxt_s;
            free_cnt_r    <= free_cnt_nxt_s;
            full_r        <= full_nxt_s;
            almost_full_r <= almost_full_nxt_s;
        end else begin
            issue_valid_r <= issue_valid_r;
            issue_entry_r <= issue_entry_r;
            rr_ptr_r      <= rr_ptr_r;
            alloc_valid_r <= alloc_valid_r;
            alloc_entry_r <= alloc_entry_r;
            free_cnt_r    <= free_cnt_r;
            full_r        <= full_r;
            almost_full_r <= almost_full_r;
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_entry = issue_entry_r;
    assign alloc_valid = alloc_valid_r;
    assign alloc_entry = alloc_entry_r;
    assign free_cnt    = free_cnt_r;
    assign full        = full_r;
    assign almost_full = almost_full_r;

endmodule : rs_sel_arb

// File: tb/tb_rs_sel_arb.sv
// Directed bench for rs_sel_arb (RS_SIZE=16, AF_THRESH=2): vector table plus
// hand-written flush, freeze and mid-handshake reset sequences.
module tb_rs_sel_arb;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, issue_ready, alloc_req;
    logic [15:0] prepared, busy;
    logic        issue_valid, alloc_valid, full, almost_full;
    logic [3:0]  issue_entry, alloc_entry;
    logic [4:0]  free_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] prep;
        logic [15:0] bsy;
        logic        rdy_e;
        logic        areq;
        logic        fl;
        logic        rdy;
        logic        iv;
        logic [3:0]  ie;
        logic        av;
        logic [3:0]  ae;
        logic [4:0]  fc;
        logic        fu;
        logic        af;
        string       name;
    } vec_t;

    vec_t vecs[17];

    rs_sel_arb #(.RS_SIZE(16), .RS_BIT(4), .AF_THRESH(2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .prepared    (prepared),
        .busy        (busy),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .issue_ready (issue_ready),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_entry (alloc_entry),
        .free_cnt    (free_cnt),
        .full        (full),
        .almost_full (almost_full)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic iv, input logic [3:0] ie,
                         input logic av, input logic [3:0] ae, input logic [4:0] fc,
                         input logic fu, input logic af);
        logic [16:0] act, exp;
        act = {issue_valid, issue_entry, alloc_valid, alloc_entry, free_cnt, full, almost_full};
        exp = {iv, ie, av, ae, fc, fu, af};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got iv=%0b ie=%0d av=%0b ae=%0d fc=%0d full=%0b af=%0b, want iv=%0b ie=%0d av=%0b ae=%0d fc=%0d full=%0b af=%0b",
                     name, issue_valid, issue_entry, alloc_valid, alloc_entry, free_cnt, full,
                     almost_full, iv, ie, av, ae, fc, fu, af);
        end
    endtask

    task automatic step(input logic [15:0] prep, input logic [15:0] bsy, input logic rdy_e,
                        input logic areq, input logic fl, input logic rdy,
                        input logic iv, input logic [3:0] ie, input logic av,
                        input logic [3:0] ae, input logic [4:0] fc, input logic fu,
                        input logic af, input string name);
        prepared    = prep;
        busy        = bsy;
        issue_ready = rdy_e;
        alloc_req   = areq;
        flush_in    = fl;
        rdy_in      = rdy;
        @(posedge clk_in);
        #1;
        check(name, iv, ie, av, ae, fc, fu, af);
    endtask

    initial begin
        //          prep      busy      rdy_e areq fl  rdy   iv  ie  av  ae  fc  full af
        vecs[0]  = '{16'h1088, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "rr_pick3"};
        vecs[1]  = '{16'h1088, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "rr_pick7"};
        vecs[2]  = '{16'h1088, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "rr_pick12"};
        vecs[3]  = '{16'h1088, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "rr_wrap3"};
        vecs[4]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "drain_empty"};
        vecs[5]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "pick5"};
        vecs[6]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "stall1"};
        vecs[7]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "stall2"};
        vecs[8]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "stall3"};
        vecs[9]  = '{16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "accept5_mask"};
        vecs[10] = '{16'h0060, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "rr_ptr6"};
        vecs[11] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "accept6"};
        vecs[12] = '{16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b0, 4'd0, 5'd0,  1'b1, 1'b1, "alloc_last"};
        vecs[13] = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b0, 4'd0, 5'd0,  1'b1, 1'b1, "full_ignore_req"};
        vecs[14] = '{16'h0000, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 4'd0, 5'd2,  1'b0, 1'b1, "almost_full2"};
        vecs[15] = '{16'h0000, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 4'd1, 5'd3,  1'b0, 1'b0, "alloc_skip0"};
        vecs[16] = '{16'h0000, 16'hFFF1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 4'd2, 5'd2,  1'b0, 1'b1, "alloc_skip1"};

        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; issue_ready = 1'b0;
        alloc_req = 1'b0; prepared = '0; busy = '0;
        #2 rst_in = 1'b0;
        #10;
        check("reset_state", 1'b0, 4'd0, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].prep, vecs[i].bsy, vecs[i].rdy_e, vecs[i].areq, vecs[i].fl, vecs[i].rdy,
                 vecs[i].iv, vecs[i].ie, vecs[i].av, vecs[i].ae, vecs[i].fc, vecs[i].fu,
                 vecs[i].af, vecs[i].name);
        end

        // Flush colliding with an accept and an alloc, then prove rr_ptr returned to 0.
        step(16'h0100, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8,  1'b1, 4'd0, 5'd4,  1'b0, 1'b0, "pre_flush_pick8");
        step(16'h0100, 16'hFFF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "flush_priority");
        step(16'h0402, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "flush_rr_zero");

        // Freeze with rdy_in low while every other input churns, then resume.
        step(16'h0402, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "pick10");
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "freeze1");
        step(16'h0008, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "freeze2");
        step(16'h1234, 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "freeze3");
        step(16'h040A, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "resume_rr2");

        // Reset in the middle of a stalled handshake drops the pick and rewinds rr_ptr.
        prepared = 16'h4008; issue_ready = 1'b0; alloc_req = 1'b0; flush_in = 1'b0; busy = '0;
        rst_in = 1'b0;
        #2;
        check("midhs_reset", 1'b0, 4'd0, 1'b1, 4'd0, 5'd16, 1'b0, 1'b0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        step(16'h4008, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd0, 5'd16, 1'b0, 1'b0, "post_reset_rr0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rs_sel_arb
